// File: rtl/onchip_mem_arbiter_if.sv
// Core-side Avalon-MM request bus and RAM s1 bus of onchip_mem_arbiter.
// ONCHIP_MEM_ARB_LOCK_EN adds the per-requester req_lock input.
interface onchip_mem_arbiter_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ADDR_W  = 13,
   parameter int unsigned DATA_W  = 32
);
   localparam int unsigned BE_W = DATA_W / 8;

   logic [NUM_REQ*ADDR_W-1:0] req_address;
   logic [NUM_REQ*BE_W-1:0]   req_byteenable;
   logic [NUM_REQ-1:0]        req_read;
   logic [NUM_REQ-1:0]        req_write;
   logic [NUM_REQ*DATA_W-1:0] req_writedata;
   logic [NUM_REQ-1:0]        req_waitrequest;
   logic [DATA_W-1:0]         req_readdata;
   logic [NUM_REQ-1:0]        req_readdatavalid;
`ifdef ONCHIP_MEM_ARB_LOCK_EN
   logic [NUM_REQ-1:0]        req_lock;
`endif

   logic [ADDR_W-1:0]         mem_address;
   logic [BE_W-1:0]           mem_byteenable;
   logic                      mem_chipselect;
   logic                      mem_write;
   logic [DATA_W-1:0]         mem_writedata;
   logic                      mem_clken;
   logic [DATA_W-1:0]         mem_readdata;

`ifdef ONCHIP_MEM_ARB_LOCK_EN
   modport slave (
      input  req_address, req_byteenable, req_read, req_write, req_writedata, req_lock,
      output req_waitrequest, req_readdata, req_readdatavalid,
      output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
      input  mem_readdata
   );
   modport master (
      output req_address, req_byteenable, req_read, req_write, req_writedata, req_lock,
      input  req_waitrequest, req_readdata, req_readdatavalid,
      input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
      output mem_readdata
   );
`else
   modport slave (
      input  req_address, req_byteenable, req_read, req_write, req_writedata,
      output req_waitrequest, req_readdata, req_readdatavalid,
      output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
      input  mem_readdata
   );
   modport master (
      output req_address, req_byteenable, req_read, req_write, req_writedata,
      input  req_waitrequest, req_readdata, req_readdatavalid,
      input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
      output mem_readdata
   );
`endif
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter sharing one single-port 1-cycle-read RAM among NUM_REQ Avalon-MM masters.
// Optional ONCHIP_MEM_ARB_LOCK_EN: a locked previous winner keeps the RAM while it keeps requesting.
module onchip_mem_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ADDR_W  = 13,
   parameter int unsigned DATA_W  = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   onchip_mem_arbiter_if.slave  bus
);
   localparam int unsigned BE_W = DATA_W / 8;
   localparam int unsigned GW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [GW-1:0]      last_grant;
   logic [GW-1:0]      grant_idx;
   logic               grant_vld;
   logic [NUM_REQ-1:0] req_c;
   logic               rd_pend;
   logic [GW-1:0]      rd_owner;
`ifdef ONCHIP_MEM_ARB_LOCK_EN
   logic               lock_owner_vld;
`endif

   function automatic logic [GW-1:0] wrap_idx(input int unsigned v);
      return GW'((v >= NUM_REQ) ? v - NUM_REQ : v);
   endfunction

   // Rotating-priority search starting one past the previous winner; nothing is granted in reset.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      req_c     = bus.req_read | bus.req_write;
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
         if (!grant_vld && req_c[wrap_idx(32'(last_grant) + off)]) begin
            grant_vld = 1'b1;
            grant_idx = wrap_idx(32'(last_grant) + off);
         end
      end
`ifdef ONCHIP_MEM_ARB_LOCK_EN
      if (lock_owner_vld && req_c[last_grant]) begin
         grant_vld = 1'b1;
         grant_idx = last_grant;
      end
`endif
      if (reset) begin
         grant_vld = 1'b0;
      end
   end

   // Same-cycle accept and RAM command mux; read return is steered to the one-cycle-old owner.
   always_comb begin
      bus.req_waitrequest   = '1;
      bus.req_readdatavalid = '0;
      bus.req_readdata      = bus.mem_readdata;
      bus.mem_chipselect    = grant_vld;
      bus.mem_write         = 1'b0;
      bus.mem_address       = '0;
      bus.mem_byteenable    = '0;
      bus.mem_writedata     = '0;
      bus.mem_clken         = 1'b1;
      if (grant_vld) begin
         bus.req_waitrequest[grant_idx] = 1'b0;
         bus.mem_write      = bus.req_write[grant_idx];
         bus.mem_address    = bus.req_address[32'(grant_idx)*ADDR_W +: ADDR_W];
         bus.mem_byteenable = bus.req_byteenable[32'(grant_idx)*BE_W +: BE_W];
         bus.mem_writedata  = bus.req_writedata[32'(grant_idx)*DATA_W +: DATA_W];
      end
      if (rd_pend && !reset) begin
         bus.req_readdatavalid[rd_owner] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= GW'(NUM_REQ - 1);
         rd_pend    <= 1'b0;
         rd_owner   <= '0;
      end else begin
         if (grant_vld) begin
            last_grant <= grant_idx;
         end
         // A simultaneous write wins, so no data is returned for that command.
         rd_pend <= grant_vld && bus.req_read[grant_idx] && !bus.req_write[grant_idx];
         if (grant_vld && bus.req_read[grant_idx] && !bus.req_write[grant_idx]) begin
            rd_owner <= grant_idx;
         end
      end
   end

`ifdef ONCHIP_MEM_ARB_LOCK_EN
   // Lock is tied to the latest winner; a grant without lock or an idle cycle drops it.
   always_ff @(posedge clk) begin
      if (reset) begin
         lock_owner_vld <= 1'b0;
      end else begin
         lock_owner_vld <= grant_vld && bus.req_lock[grant_idx];
      end
   end
`endif

endmodule
